// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset/start sequencer.
// Holds the per-channel state encoding and the default parameter constants
// used by rst_seq_chan and rst_seq_ctrl.
package rst_seq_pkg;

   localparam int unsigned DEF_N_CH    = 4;
   localparam int unsigned DEF_PULSE_W = 2;
   localparam int unsigned DEF_TO_W    = 16;
   localparam int unsigned DEF_TIMEOUT = 1000;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StPulse = 2'd1,
      StRun   = 2'd2
   } seq_state_e;

endpackage

// File: rtl/rst_seq_chan.sv
// One reset/start channel: IDLE -> PULSE (PULSE_W cycles of reset) -> RUN
// until done_collide, run timeout or abort.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   cs           - start request level (rising edge starts a sequence)
//   done_collide - completion from the collision core (honoured in RUN only)
//   abort        - forces IDLE next cycle, overrides done and timeout
//   clr_err      - clears the sticky timeout flag
//   rst_out      - registered active-high reset, low exactly while in RUN
//   busy         - state is not IDLE (combinational from the state register)
//   done_pulse   - registered one-cycle completion strobe
//   timeout_err  - sticky run-timeout flag
module rst_seq_chan
   import rst_seq_pkg::*;
#(
   parameter int unsigned PULSE_W = DEF_PULSE_W,
   parameter int unsigned TO_W    = DEF_TO_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic cs,
   input  logic done_collide,
   input  logic abort,
   input  logic clr_err,
   output logic rst_out,
   output logic busy,
   output logic done_pulse,
   output logic timeout_err
);

   localparam int unsigned PCW = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
   localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_W - 1);
   // Run-counter value on the last permitted RUN cycle; unused when TIMEOUT is 0.
   localparam logic [TO_W-1:0] RUN_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   seq_state_e      state_q, state_d;
   logic [PCW-1:0]  pcnt_q, pcnt_d;
   logic [TO_W-1:0] rcnt_q, rcnt_d;
   logic            cs_q;
   logic            rst_out_q, done_q, err_q;
   logic            done_d, err_d;
   logic            start;

   assign start = cs & ~cs_q;

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      rcnt_d  = rcnt_q;
      done_d  = 1'b0;
      err_d   = clr_err ? 1'b0 : err_q;

      unique case (state_q)
         StIdle: begin
            rcnt_d = '0;
            if (start) begin
               state_d = StPulse;
               pcnt_d  = PULSE_LOAD;
            end
         end
         StPulse: begin
            if (pcnt_q == '0) begin
               state_d = StRun;
               rcnt_d  = '0;
            end else begin
               pcnt_d = pcnt_q - 1'b1;
            end
         end
         StRun: begin
            if (rcnt_q != '1) rcnt_d = rcnt_q + 1'b1;
            // Done takes precedence over a coincident timeout.
            if (done_collide) begin
               state_d = StIdle;
               done_d  = 1'b1;
               rcnt_d  = '0;
            end else if ((TIMEOUT != 0) && (rcnt_q == RUN_LAST)) begin
               state_d = StIdle;
               err_d   = 1'b1;
               rcnt_d  = '0;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort wins over everything except rst; it neither strobes done nor sets the error.
      if (abort) begin
         state_d = StIdle;
         pcnt_d  = '0;
         rcnt_d  = '0;
         done_d  = 1'b0;
         err_d   = clr_err ? 1'b0 : err_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         pcnt_q    <= '0;
         rcnt_q    <= '0;
         cs_q      <= 1'b1; // a cs held high through reset is not an edge
         rst_out_q <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pcnt_q    <= pcnt_d;
         rcnt_q    <= rcnt_d;
         cs_q      <= cs;
         rst_out_q <= (state_d != StRun);
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign rst_out     = rst_out_q;
   assign busy        = (state_q != StIdle);
   assign done_pulse  = done_q;
   assign timeout_err = err_q;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Multi-channel reset/start sequencer for the collision core.
// Each channel is an independent rst_seq_chan; this level only fans out
// abort/clr_err and packs the per-channel signals into vectors.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   cs           - [N_CH] start request levels
//   done_collide - [N_CH] completion levels from the collision core
//   abort        - global abort to IDLE
//   clr_err      - clears all timeout_err bits
//   rstOut       - [N_CH] registered active-high resets to the core
//   busy         - [N_CH] channel not IDLE
//   done_pulse   - [N_CH] one-cycle completion strobes
//   timeout_err  - [N_CH] sticky timeout flags
module rst_seq_ctrl
   import rst_seq_pkg::*;
#(
   parameter int unsigned N_CH    = DEF_N_CH,
   parameter int unsigned PULSE_W = DEF_PULSE_W,
   parameter int unsigned TO_W    = DEF_TO_W,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] cs,
   input  logic [N_CH-1:0] done_collide,
   input  logic            abort,
   input  logic            clr_err,
   output logic [N_CH-1:0] rstOut,
   output logic [N_CH-1:0] busy,
   output logic [N_CH-1:0] done_pulse,
   output logic [N_CH-1:0] timeout_err
);

   for (genvar i = 0; i < N_CH; i++) begin : g_chan
      rst_seq_chan #(
         .PULSE_W (PULSE_W),
         .TO_W    (TO_W),
         .TIMEOUT (TIMEOUT)
      ) u_chan (
         .clk          (clk),
         .rst          (rst),
         .cs           (cs[i]),
         .done_collide (done_collide[i]),
         .abort        (abort),
         .clr_err      (clr_err),
         .rst_out      (rstOut[i]),
         .busy         (busy[i]),
         .done_pulse   (done_pulse[i]),
         .timeout_err  (timeout_err[i])
      );
   end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with N_CH=2, PULSE_W=2, TIMEOUT=8.
// Cycle n is the interval after the n-th clock edge following reset release;
// inputs set in cycle n are sampled at the edge ending it.
module tb_rst_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] cs, done_collide;
   logic       abort, clr_err;
   logic [1:0] rstOut, busy, done_pulse, timeout_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   rst_seq_ctrl #(
      .N_CH    (2),
      .PULSE_W (2),
      .TO_W    (16),
      .TIMEOUT (8)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cs           (cs),
      .done_collide (done_collide),
      .abort        (abort),
      .clr_err      (clr_err),
      .rstOut       (rstOut),
      .busy         (busy),
      .done_pulse   (done_pulse),
      .timeout_err  (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc%0d: got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) step();
   endtask

   // Leaves cs at the given level through reset, then releases it in cycle 0.
   task automatic do_reset(input logic [1:0] cs_lvl);
      rst = 1'b1; cs = cs_lvl; done_collide = 2'b00; abort = 1'b0; clr_err = 1'b0;
      step();
      step();
      rst = 1'b0;
      cyc = 0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".rstOut"}, 8'(rstOut), 8'b11);
      chk({tag, ".busy"}, 8'(busy), 8'b00);
      chk({tag, ".done"}, 8'(done_pulse), 8'b00);
      chk({tag, ".err"}, 8'(timeout_err), 8'b00);
   endtask

   initial begin
      // Reset values
      do_reset(2'b00);
      chk_idle("reset");

      // Normal start/done on channel 0, with cs left high afterwards
      goto(10); cs = 2'b01;
      step(); chk("s1.busy11", 8'(busy), 8'b01);
      chk("s1.rst11", 8'(rstOut), 8'b11);
      step(); chk("s1.rst12", 8'(rstOut), 8'b11);
      step(); chk("s1.rst13", 8'(rstOut), 8'b10);
      goto(20); chk("s1.rst20", 8'(rstOut), 8'b10);
      chk("s1.busy20", 8'(busy), 8'b01);
      done_collide = 2'b01;
      step(); chk("s1.done21", 8'(done_pulse), 8'b01);
      chk("s1.busy21", 8'(busy), 8'b00);
      chk("s1.rst21", 8'(rstOut), 8'b11);
      chk("s1.err21", 8'(timeout_err), 8'b00);
      done_collide = 2'b00;
      step(); chk("s1.done22", 8'(done_pulse), 8'b00);
      goto(25); chk("s1.norestart", 8'(busy), 8'b00);

      // Timeout on channel 1, then clr_err
      do_reset(2'b00);
      goto(10); cs = 2'b10;
      goto(13); chk("s2.rst13", 8'(rstOut), 8'b01);
      goto(20); chk("s2.rst20", 8'(rstOut), 8'b01);
      chk("s2.err20", 8'(timeout_err), 8'b00);
      step(); chk("s2.err21", 8'(timeout_err), 8'b10);
      chk("s2.busy21", 8'(busy), 8'b00);
      chk("s2.done21", 8'(done_pulse), 8'b00);
      chk("s2.rst21", 8'(rstOut), 8'b11);
      goto(25); chk("s2.err25", 8'(timeout_err), 8'b10);
      clr_err = 1'b1;
      step(); chk("s2.err26", 8'(timeout_err), 8'b00);
      clr_err = 1'b0; cs = 2'b00;

      // Done coincides with timeout on channel 1
      do_reset(2'b00);
      goto(10); cs = 2'b10;
      goto(20); done_collide = 2'b10;
      step(); chk("s3.done21", 8'(done_pulse), 8'b10);
      chk("s3.err21", 8'(timeout_err), 8'b00);
      done_collide = 2'b00; cs = 2'b00;

      // Repeated cs edges during an active sequence are ignored
      do_reset(2'b00);
      goto(10); cs = 2'b01;
      goto(11); cs = 2'b00;
      goto(12); cs = 2'b01;
      goto(13); cs = 2'b00;
      chk("s4.rst13", 8'(rstOut), 8'b10);
      goto(15); cs = 2'b01;
      goto(16); cs = 2'b00;
      chk("s4.rst16", 8'(rstOut), 8'b10);
      goto(18); done_collide = 2'b01;
      step(); chk("s4.done19", 8'(done_pulse), 8'b01);
      done_collide = 2'b00;
      step(); chk("s4.done20", 8'(done_pulse), 8'b00);
      chk("s4.busy20", 8'(busy), 8'b00);

      // cs held high through reset release: no start
      do_reset(2'b11);
      goto(4); chk("s5.busy", 8'(busy), 8'b00);
      chk("s5.rst", 8'(rstOut), 8'b11);

      // Abort during RUN, coincident with done on channel 0
      do_reset(2'b00);
      goto(10); cs = 2'b11;
      goto(15); chk("s6.busy15", 8'(busy), 8'b11);
      abort = 1'b1; done_collide = 2'b01;
      step(); chk_idle("s6.abort16");
      abort = 1'b0; done_collide = 2'b00;
      goto(22); chk("s6.err22", 8'(timeout_err), 8'b00);
      chk("s6.busy22", 8'(busy), 8'b00);
      cs = 2'b00;

      // rst mid-RUN, then a fresh start
      do_reset(2'b00);
      goto(10); cs = 2'b01;
      goto(11); cs = 2'b00;
      goto(14); chk("s7.rst14", 8'(rstOut), 8'b10);
      rst = 1'b1;
      step(); rst = 1'b0;
      chk_idle("s7.rst15");
      goto(17); cs = 2'b01;
      step(); chk("s7.busy18", 8'(busy), 8'b01);
      goto(20); chk("s7.rst20", 8'(rstOut), 8'b10);
      cs = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
